sopc_system_linux_cpu_oci_dct_packer: RTL and testbench



---
 rtl/sopc_system_linux_cpu_oci_dct_pkg.sv | 25 ++
 rtl/sopc_system_linux_cpu_oci_dct_frame_reg.sv | 62 ++++++
 rtl/sopc_system_linux_cpu_oci_dct_packer.sv | 165 ++++++++++++++++
 tb/tb_sopc_system_linux_cpu_oci_dct_packer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sopc_system_linux_cpu_oci_dct_pkg.sv
// Shared constants and types for the OCI trace DCT atom packer.
// Optional DCT_TIMESTAMP_EN adds a 16-bit frame timestamp (see DCT_TS_W).
package sopc_system_linux_cpu_oci_dct_pkg;

  localparam logic [1:0] DCT_ATOM_NONE = 2'b00;
  localparam logic [1:0] DCT_ATOM_NT   = 2'b01;
  localparam logic [1:0] DCT_ATOM_TK   = 2'b10;
  localparam logic [1:0] DCT_ATOM_IND  = 2'b11;

  localparam int unsigned DCT_MAX_ATOMS = 15;
  localparam int unsigned DCT_BUF_W     = 30;
  localparam int unsigned DCT_CNT_W     = 4;
  localparam int unsigned DCT_TS_W      = 16;

  // Working register either collects atoms or holds a completed frame waiting for the output.
  typedef enum logic {
    WORK_FILL,
    WORK_PEND
  } work_state_e;

  function automatic logic dct_atom_is_real(input logic [1:0] a);
    return a != DCT_ATOM_NONE;
  endfunction

endpackage

// File: rtl/sopc_system_linux_cpu_oci_dct_frame_reg.sv
// Output frame register with valid/ready hold; data stays stable until accepted.
// With DCT_TIMESTAMP_EN defined, also holds the frame timestamp.
module sopc_system_linux_cpu_oci_dct_frame_reg
  import sopc_system_linux_cpu_oci_dct_pkg::*;
#(
  parameter int unsigned BUF_W = DCT_BUF_W,
  parameter int unsigned CNT_W = DCT_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [BUF_W-1:0]   i_buf,
  input  logic [CNT_W-1:0]   i_cnt,
`ifdef DCT_TIMESTAMP_EN
  input  logic [DCT_TS_W-1:0] i_ts,
  output logic [DCT_TS_W-1:0] o_ts,
`endif
  input  logic               i_ready,
  output logic               o_valid,
  output logic [BUF_W-1:0]   o_buf,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_free
);

  logic             r_valid;
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_buf   <= i_buf;
      r_cnt   <= i_cnt;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DCT_TIMESTAMP_EN
  logic [DCT_TS_W-1:0] r_ts;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ts <= '0;
    end else if (i_load) begin
      r_ts <= i_ts;
    end
  end

  assign o_ts = r_ts;
`endif

  assign o_valid = r_valid;
  assign o_buf   = r_buf;
  assign o_cnt   = r_cnt;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/sopc_system_linux_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into frames of up to MAX_ATOMS, double-buffered.
// Define DCT_TIMESTAMP_EN to add the dct_timestamp output and cycle counter.
module sopc_system_linux_cpu_oci_dct_packer
  import sopc_system_linux_cpu_oci_dct_pkg::*;
#(
  parameter int unsigned MAX_ATOMS = DCT_MAX_ATOMS,
  parameter int unsigned BUF_W     = 2 * MAX_ATOMS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trace_en,
  input  logic             atom_valid,
  input  logic [1:0]       atom,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic             overflow,
  input  logic             overflow_clr
`ifdef DCT_TIMESTAMP_EN
  ,
  output logic [DCT_TS_W-1:0] dct_timestamp
`endif
);

  localparam int unsigned CNT_W = DCT_CNT_W;

  work_state_e r_state;
  work_state_e w_state_nxt;

  logic [BUF_W-1:0] r_work_buf;
  logic [CNT_W-1:0] r_work_cnt;
  logic             r_overflow;

  logic             w_pending;
  logic             w_atom_live;
  logic             w_acc;
  logic             w_drop;
  logic [BUF_W-1:0] w_buf_upd;
  logic [CNT_W-1:0] w_cnt_upd;
  logic             w_complete;
  logic             w_out_free;
  logic             w_load;
  logic             w_clear;
  logic [BUF_W-1:0] w_load_buf;
  logic [CNT_W-1:0] w_load_cnt;

  assign w_pending   = (r_state == WORK_PEND);
  assign w_atom_live = trace_en && atom_valid && dct_atom_is_real(atom);
  assign w_acc       = w_atom_live && !w_pending;
  assign w_drop      = w_atom_live && w_pending;

  assign w_buf_upd = w_acc ? ((r_work_buf << 2) | BUF_W'(atom)) : r_work_buf;
  assign w_cnt_upd = r_work_cnt + CNT_W'(w_acc);

  // Completion looks at the post-update count so a same-cycle atom joins a flushed frame.
  assign w_complete = !w_pending &&
                      ((w_acc && (w_cnt_upd == CNT_W'(MAX_ATOMS))) ||
                       (flush && (w_cnt_upd != '0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WORK_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WORK_FILL: if (w_complete && !w_out_free) w_state_nxt = WORK_PEND;
      WORK_PEND: if (out_ready)                 w_state_nxt = WORK_FILL;
      default:                                  w_state_nxt = WORK_FILL;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_clear    = 1'b0;
    w_load_buf = w_buf_upd;
    w_load_cnt = w_cnt_upd;
    case (r_state)
      WORK_FILL: begin
        if (w_complete && w_out_free) begin
          w_load  = 1'b1;
          w_clear = 1'b1;
        end
      end
      WORK_PEND: begin
        // Output is always occupied while pending, so out_ready alone means it is accepted.
        if (out_ready) begin
          w_load     = 1'b1;
          w_clear    = 1'b1;
          w_load_buf = r_work_buf;
          w_load_cnt = r_work_cnt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work_buf <= '0;
      r_work_cnt <= '0;
    end else if (w_clear) begin
      r_work_buf <= '0;
      r_work_cnt <= '0;
    end else begin
      r_work_buf <= w_buf_upd;
      r_work_cnt <= w_cnt_upd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

`ifdef DCT_TIMESTAMP_EN
  logic [DCT_TS_W-1:0] r_ts_cnt;
  logic [DCT_TS_W-1:0] w_ts_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
    end
  end

  // Latch the counter value it takes on at the handoff edge.
  assign w_ts_load = r_ts_cnt + 1'b1;
`endif

  sopc_system_linux_cpu_oci_dct_frame_reg #(
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_frame_reg (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_buf   (w_load_buf),
    .i_cnt   (w_load_cnt),
`ifdef DCT_TIMESTAMP_EN
    .i_ts    (w_ts_load),
    .o_ts    (dct_timestamp),
`endif
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_buf   (dct_buffer),
    .o_cnt   (dct_count),
    .o_free  (w_out_free)
  );

endmodule

// File: tb/tb_sopc_system_linux_cpu_oci_dct_packer.sv
// Directed self-checking bench for the DCT atom packer.
// Define DCT_TIMESTAMP_EN to also exercise the frame timestamp.
module tb_sopc_system_linux_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        overflow_clr;
`ifdef DCT_TIMESTAMP_EN
  logic [15:0] dct_timestamp;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sopc_system_linux_cpu_oci_dct_packer #(
    .MAX_ATOMS (15),
    .BUF_W     (30)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trace_en     (trace_en),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef DCT_TIMESTAMP_EN
    ,
    .dct_timestamp (dct_timestamp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) begin
      atom_valid = 1'b1;
      atom       = a;
      tick();
    end
    atom_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b0; atom_valid = 1'b0; atom = 2'b00;
    flush = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_buf",   {2'b0, dct_buffer}, 32'h0);
    chk("rst_cnt",   {28'b0, dct_count}, 32'h0);
    chk("rst_ovf",   {31'b0, overflow},  32'h0);
    reset = 1'b0;

    // Full frame of 15 taken atoms
    out_ready = 1'b1; trace_en = 1'b1;
    feed(14, 2'b10);
    chk("full_early_valid", {31'b0, out_valid}, 32'h0);
    feed(1, 2'b10);
    chk("full_valid", {31'b0, out_valid}, 32'h1);
    chk("full_buf",   {2'b0, dct_buffer}, 32'h2AAAAAAA);
    chk("full_cnt",   {28'b0, dct_count}, 32'd15);
    tick();
    chk("full_drop_valid", {31'b0, out_valid}, 32'h0);

    // Partial frame by flush; second flush with empty buffer
    feed(1, 2'b01); feed(1, 2'b11); feed(1, 2'b10);
    flush = 1'b1; tick();
    chk("flush_valid", {31'b0, out_valid}, 32'h1);
    chk("flush_buf",   {2'b0, dct_buffer}, 32'h1E);
    chk("flush_cnt",   {28'b0, dct_count}, 32'd3);
    tick();
    chk("flush_empty_valid", {31'b0, out_valid}, 32'h0);
    flush = 1'b0; tick();
    chk("flush_empty_valid2", {31'b0, out_valid}, 32'h0);

    // Stall: first frame held, second pending, 31st atom dropped
    out_ready = 1'b0;
    feed(15, 2'b01);
    chk("stall_a_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_a_buf",   {2'b0, dct_buffer}, 32'h15555555);
    feed(15, 2'b11);
    chk("stall_hold_buf", {2'b0, dct_buffer}, 32'h15555555);
    chk("stall_hold_cnt", {28'b0, dct_count}, 32'd15);
    chk("stall_ovf0",     {31'b0, overflow},  32'h0);
    overflow_clr = 1'b1;
    feed(1, 2'b01);
    overflow_clr = 1'b0;
    chk("ovf_set_prio", {31'b0, overflow}, 32'h1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pend_flush_buf", {2'b0, dct_buffer}, 32'h15555555);
    out_ready = 1'b1; tick();
    chk("pend_b_valid", {31'b0, out_valid}, 32'h1);
    chk("pend_b_buf",   {2'b0, dct_buffer}, 32'h3FFFFFFF);
    chk("pend_b_cnt",   {28'b0, dct_count}, 32'd15);
    tick();
    chk("pend_done_valid", {31'b0, out_valid}, 32'h0);
    chk("ovf_sticky",      {31'b0, overflow},  32'h1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf_clr", {31'b0, overflow}, 32'h0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("no_leak_valid", {31'b0, out_valid}, 32'h0);

    // Atom and flush together
    feed(4, 2'b01);
    atom_valid = 1'b1; atom = 2'b11; flush = 1'b1; tick();
    atom_valid = 1'b0; flush = 1'b0;
    chk("same_cyc_cnt", {28'b0, dct_count}, 32'd5);
    chk("same_cyc_buf", {2'b0, dct_buffer}, 32'h157);
    tick();

    // trace_en low ignores atoms but keeps the partial frame
    feed(1, 2'b10);
    trace_en = 1'b0;
    feed(1, 2'b11);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("en_low_valid", {31'b0, out_valid}, 32'h1);
    chk("en_low_cnt",   {28'b0, dct_count}, 32'd1);
    chk("en_low_buf",   {2'b0, dct_buffer}, 32'h2);
    trace_en = 1'b1; tick();

    // Reset with an output frame and a pending frame
    out_ready = 1'b0;
    feed(30, 2'b10);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1; #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_buf",   {2'b0, dct_buffer}, 32'h0);
    chk("mid_rst_cnt",   {28'b0, dct_count}, 32'h0);
    tick(); reset = 1'b0;
    out_ready = 1'b1;
    feed(1, 2'b10);
    atom_valid = 1'b1; atom = 2'b01; flush = 1'b1; tick();
    atom_valid = 1'b0; flush = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
    chk("post_rst_cnt",   {28'b0, dct_count}, 32'd2);
    chk("post_rst_buf",   {2'b0, dct_buffer}, 32'h9);
    tick();
    chk("post_rst_drop", {31'b0, out_valid}, 32'h0);

`ifdef DCT_TIMESTAMP_EN
    reset = 1'b1; tick(); reset = 1'b0;
    cyc = 0;
    feed(1, 2'b10);
    while (cyc != 16) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ts_valid", {31'b0, out_valid}, 32'h1);
    chk("ts_val",   {16'b0, dct_timestamp}, 32'h0011);
    tick();
    feed(1, 2'b01);
    while (cyc != 32'hFFFF) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ts_wrap_valid", {31'b0, out_valid}, 32'h1);
    chk("ts_wrap",       {16'b0, dct_timestamp}, 32'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
